mdu_arbiter: RTL and testbench
==============================

# mdu_arbiter

Sequencer and round-robin arbiter that shares one iterative multiply/divide/carry-less-multiply unit (MDU) between `NUM_REQ` requesters, for example two issue lanes or EXU plus a crypto helper. It owns the MDU's start/done handshake and latches operands for the whole operation. It returns each result to the requester that issued it and aborts cleanly on pipeline flush. It sits between the backend issue logic and the MDU, and replaces direct per-lane MDU instantiation.

## Interface
- `NUM_REQ`, 2, number of requesters (2..4)
- `TIMEOUT`, 64, max cycles to wait for `unit_done` before forced abort
- `clk` in 1: clock
- `rst` in 1: synchronous, active-low reset (`rst==0` resets on rising `clk`)
- `flush` in 1: pipeline flush; kills any queued or in-flight operation
- `req_valid` in `NUM_REQ`: request present, per requester
- `req_ready` out `NUM_REQ`: request accepted this cycle (one-hot or zero)
- `req_op` in `NUM_REQ`×`op_t`: micro-op (`OP_MUL*`, `OP_DIV*`, `OP_REM*`, `OP_CLMUL*`)
- `req_rs1`, `req_rs2` in `NUM_REQ`×32: operands
- `unit_start` out 1: one-cycle start pulse to the MDU
- `unit_kill` out 1: one-cycle abort pulse to the MDU
- `unit_op` out `op_t`: latched op, held stable from `unit_start` until done or kill
- `unit_rs1`, `unit_rs2` out 32: latched operands, held stable like `unit_op`
- `unit_done` in 1: MDU result valid, one-cycle pulse
- `unit_result` in 32: MDU result, already selected per op
- `resp_valid` out `NUM_REQ`: one-hot, one-cycle result pulse to the owner
- `resp_data` out 32: result
- `timeout_err` out 1: one-cycle pulse when the watchdog fires
- `busy` out 1: high in any state other than IDLE

## Operation
- FSM states are IDLE, START, WAIT and RESP.
- **IDLE:**
  - If any `req_valid` is set, pick the winner round-robin, starting one past `last_grant`.
  - Assert `req_ready[winner]` combinationally.
  - Latch op, operands and `owner = winner`, then go to START.
- **START:**
  - Assert `unit_start` for exactly one cycle.
  - Clear the watchdog counter and go to WAIT.
- **WAIT:**
  - Increment the counter each cycle.
  - On `unit_done`, latch `unit_result` into `resp_data` and go to RESP.
  - If the counter reaches `TIMEOUT-1` without `unit_done`, pulse `unit_kill` and `timeout_err`, then go to IDLE. No response is issued.
- **RESP:**
  - Pulse `resp_valid[owner]`.
  - Set `last_grant = owner` and go to IDLE. A new grant is allowed in that IDLE cycle.
- `req_ready` is 0 in every state except IDLE.
- A requester must hold `req_valid` and its operands until it sees `req_ready`.
- Non-MDU ops on `req_op` are a requester error. The block forwards them unchanged.
- **Flush:**
  - Flush takes priority over every other transition.
  - In IDLE: no grant; `req_ready` is all zero.
  - In START: no `unit_start`; go to IDLE.
  - In WAIT: pulse `unit_kill`; go to IDLE. A `unit_done` in the same cycle is discarded.
  - In RESP: suppress `resp_valid`; go to IDLE.
  - `last_grant` is unchanged by flush.
- **Reset:**
  - State is IDLE.
  - `last_grant = NUM_REQ-1`, so requester 0 wins first.
  - Counter is 0.
  - All outputs are 0: `req_ready`, `unit_start`, `unit_kill`, `resp_valid`, `timeout_err`, `busy`, `resp_data`, `unit_op`, `unit_rs1`, `unit_rs2`.
- Reset mid-operation behaves as an abort but does not drive `unit_kill`. The MDU is reset by the same `rst`.

## Timing
- Accept at cycle T → `unit_start` at T+1 → `unit_done` at T+1+L → `resp_valid` at T+2+L. L is the MDU latency and is at least 1.
- Back-to-back throughput is one operation per L+3 cycles: RESP to IDLE costs one cycle, and the grant is issued in IDLE.
- `req_ready` is combinational from `req_valid`, state and `last_grant`. All other outputs are registered.
- `unit_done` arriving in any state other than WAIT is ignored.
- The watchdog counter is `$clog2(TIMEOUT)` bits wide and saturates. It never wraps.

## Structure
- Package `bundle`: add enum `mdu_arb_state_t` (IDLE, START, WAIT, RESP) and struct `mdu_req_t` {op, rs1, rs2}.
- Ops come from package `micro_ops`.
- Sub-module `rr_arbiter` (parameter `N`): inputs `req`, `last_grant`; output `grant`, one-hot. It is purely combinational and reusable for LSU and FPU sharing.

## Test plan
- **Single request:** req0 issues `OP_MUL` 7×6 with an MDU model of L=3.
  - `unit_start` at T+1, `resp_valid=2'b01` with `resp_data=42` at T+5, `busy` high for 5 cycles.
- **Contention:** req0 and req1 both valid continuously.
  - Grants alternate 0,1,0,1.
  - The first grant after reset goes to 0.
  - Each response goes only to its owner; for `OP_DIVU` 100/7 the result is 14.
- **Flush in WAIT:** flush asserted the same cycle as `unit_done`.
  - `unit_kill` pulses, no `resp_valid`, state is IDLE next cycle.
  - The next request completes normally.
- **Flush in RESP:** `resp_valid` is suppressed and `last_grant` is unchanged, so the same requester wins next.
- **Timeout:** `TIMEOUT=8`, MDU never asserts done.
  - `unit_kill` and `timeout_err` pulse 8 cycles after `unit_start`.
  - No response is issued and `busy` then drops.
- **Reset mid-WAIT:** `rst=0` for one cycle.
  - All outputs are 0 next cycle.
  - A late `unit_done` is ignored and no `resp_valid` is issued.

Source files
------------

// File: rtl/mdu_arbiter_pkg.sv
// Shared micro-op encoding plus the arbiter-side state and request types.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package micro_ops;
    // Non-MDU ops share the encoding space; the arbiter forwards any value.
    typedef enum logic [4:0] {
        OP_NOP    = 5'd0,
        OP_ADD    = 5'd1,
        OP_MUL    = 5'd8,
        OP_MULH   = 5'd9,
        OP_MULHSU = 5'd10,
        OP_MULHU  = 5'd11,
        OP_DIV    = 5'd12,
        OP_DIVU   = 5'd13,
        OP_REM    = 5'd14,
        OP_REMU   = 5'd15,
        OP_CLMUL  = 5'd16,
        OP_CLMULH = 5'd17,
        OP_CLMULR = 5'd18
    } op_t;
endpackage

package bundle;
    import micro_ops::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mdu_arb_state_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } mdu_req_t;
endpackage

// File: rtl/mdu_arbiter_rr_arbiter.sv
// Round-robin one-hot grant; search starts one past last_grant and wraps.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant
);

    logic [IW-1:0] idx;
    logic          found;

    // Walk the requesters in rotated order and keep the first active one.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last_grant) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdu_arbiter.sv
// Shares one iterative MDU between NUM_REQ requesters and routes results back to the issuer.
// Latency: accept T -> unit_start T+1 -> unit_done T+1+L -> resp_valid T+2+L.
// Backpressure: req_ready only in IDLE; one op in flight; flush aborts, watchdog kills after TIMEOUT.
module mdu_arbiter
    import micro_ops::*;
    import bundle::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  op_t                req_op  [NUM_REQ],
    input  logic [31:0]        req_rs1 [NUM_REQ],
    input  logic [31:0]        req_rs2 [NUM_REQ],
    output logic               unit_start,
    output logic               unit_kill,
    output op_t                unit_op,
    output logic [31:0]        unit_rs1,
    output logic [31:0]        unit_rs2,
    input  logic               unit_done,
    input  logic [31:0]        unit_result,
    output logic [NUM_REQ-1:0] resp_valid,
    output logic [31:0]        resp_data,
    output logic               timeout_err,
    output logic               busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    mdu_arb_state_t     state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    mdu_req_t           req_q, req_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic [NUM_REQ-1:0] resp_vld_q, resp_vld_d;
    logic               start_q, start_d;
    logic               kill_q, kill_d;
    logic               tmo_q, tmo_d;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      win;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    // Encode the one-hot grant as an owner index.
    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win = IW'(i);
        end
    end

    // Watchdog count saturates so a stuck unit can never wrap it back below the limit.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Sequencer: grant in IDLE, start pulse, wait for done or watchdog, return result.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        resp_data_d = resp_data_q;
        resp_vld_d  = '0;
        start_d     = 1'b0;
        kill_d      = 1'b0;
        tmo_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush && (|grant)) begin
                    req_d   = '{op: req_op[win], rs1: req_rs1[win], rs2: req_rs2[win]};
                    owner_d = win;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                state_d = flush ? IDLE : WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (flush) begin
                    kill_d  = 1'b1;
                    state_d = IDLE;
                end else if (unit_done) begin
                    resp_data_d         = unit_result;
                    resp_vld_d[owner_q] = 1'b1;
                    state_d             = RESP;
                end else if (cnt_inc == CW'(TIMEOUT - 1)) begin
                    kill_d  = 1'b1;
                    tmo_d   = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                // A flushed response leaves the round-robin pointer where it was.
                if (!flush) last_d = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= IW'(NUM_REQ - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            req_q       <= '0;
            resp_data_q <= '0;
            resp_vld_q  <= '0;
            start_q     <= 1'b0;
            kill_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            resp_data_q <= resp_data_d;
            resp_vld_q  <= resp_vld_d;
            start_q     <= start_d;
            kill_q      <= kill_d;
            tmo_q       <= tmo_d;
        end
    end

    // Start and response pulses live in the START/RESP cycle itself, so a flush
    // arriving in that cycle can only cancel them by masking the registered pulse.
    assign req_ready   = (state_q == IDLE && !flush) ? grant : '0;
    assign unit_start  = start_q & ~flush;
    assign resp_valid  = resp_vld_q & {NUM_REQ{~flush}};
    assign unit_kill   = kill_q;
    assign timeout_err = tmo_q;
    assign unit_op     = req_q.op;
    assign unit_rs1    = req_q.rs1;
    assign unit_rs2    = req_q.rs2;
    assign resp_data   = resp_data_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed bench for mdu_arbiter with a fixed-latency MDU model (L=3) and TIMEOUT=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_mdu_arbiter;
    import micro_ops::*;

    localparam int MDU_L = 3;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [1:0]  req_valid, req_ready;
    op_t         req_op  [2];
    logic [31:0] req_rs1 [2];
    logic [31:0] req_rs2 [2];
    logic        unit_start, unit_kill, unit_done;
    op_t         unit_op;
    logic [31:0] unit_rs1, unit_rs2, unit_result;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        timeout_err, busy;

    logic        mdu_done, tb_done, mdu_en;
    int          mdu_cnt;
    int          n_chk, n_fail;

    int          st_at, kl_at, to_at, rv_at, idle_at, busy_n;
    logic [1:0]  g0, rv;
    logic [31:0] rd;
    logic        snap_any;

    logic [1:0]  gseq [4];
    logic [1:0]  rseq [4];
    logic [31:0] dseq [4];
    int          ng, nr;

    mdu_arbiter #(.NUM_REQ(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .unit_start(unit_start), .unit_kill(unit_kill),
        .unit_op(unit_op), .unit_rs1(unit_rs1), .unit_rs2(unit_rs2),
        .unit_done(unit_done), .unit_result(unit_result),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    assign unit_done = mdu_done | tb_done;

    function automatic logic [31:0] mdu_model(input op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_MUL:  return a * b;
            OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // MDU model: done pulse L cycles after the start pulse, cancelled by kill or reset.
    always @(negedge clk) begin
        mdu_done = 1'b0;
        if (unit_kill || !rst) begin
            mdu_cnt = 0;
        end else if (mdu_cnt != 0) begin
            mdu_cnt = mdu_cnt - 1;
            if (mdu_cnt == 0 && mdu_en) mdu_done = 1'b1;
        end
        if (unit_start) begin
            mdu_cnt     = MDU_L;
            unit_result = mdu_model(unit_op, unit_rs1, unit_rs2);
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        adv();
        rst = 1'b0; flush = 1'b0; req_valid = 2'b00; tb_done = 1'b0;
        adv();
        rst = 1'b1;
        smp();
    endtask

    // Present vld in cycle 0, then run n more cycles recording event cycle numbers.
    task automatic observe(input logic [1:0] vld, input int n, input int flush_at,
                           input int done_at, input int rst_at, input int snap_at);
        st_at = -1; kl_at = -1; to_at = -1; rv_at = -1; idle_at = -1; busy_n = 0;
        g0 = 2'b00; rv = 2'b00; rd = 32'd0; snap_any = 1'b1;
        for (int k = 0; k <= n; k++) begin
            adv();
            req_valid = (k == 0) ? vld : 2'b00;
            flush     = (k == flush_at);
            tb_done   = (k == done_at);
            rst       = (k != rst_at);
            smp();
            if (k == 0) g0 = req_ready;
            if (busy) busy_n++;
            if (unit_start && st_at < 0) st_at = k;
            if (unit_kill && kl_at < 0) kl_at = k;
            if (timeout_err && to_at < 0) to_at = k;
            if ((|resp_valid) && rv_at < 0) begin
                rv_at = k; rv = resp_valid; rd = resp_data;
            end
            if (k > 0 && !busy && idle_at < 0) idle_at = k;
            if (k == snap_at)
                snap_any = |{req_ready, unit_start, unit_kill, resp_valid, timeout_err,
                             busy, resp_data, unit_op, unit_rs1, unit_rs2};
        end
        flush = 1'b0; tb_done = 1'b0; rst = 1'b1; req_valid = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0; flush = 1'b0; req_valid = 2'b00; tb_done = 1'b0;
        mdu_en = 1'b1; mdu_cnt = 0; mdu_done = 1'b0; unit_result = 32'd0;
        for (int i = 0; i < 2; i++) begin
            req_op[i] = OP_NOP; req_rs1[i] = 32'd0; req_rs2[i] = 32'd0;
        end

        // Reset state
        do_reset();
        chk("reset_outputs_zero", 32'(|{req_ready, unit_start, unit_kill, resp_valid, timeout_err,
                                        busy, resp_data, unit_op, unit_rs1, unit_rs2}), 32'd0);

        // Single request: 7*6 from requester 0
        req_op[0] = OP_MUL; req_rs1[0] = 32'd7; req_rs2[0] = 32'd6;
        observe(2'b01, 7, -1, -1, -1, -1);
        chk("single_ready", 32'(g0), 32'h1);
        chk("single_start_cycle", st_at, 1);
        chk("single_resp_cycle", rv_at, 5);
        chk("single_resp_owner", 32'(rv), 32'h1);
        chk("single_resp_data", rd, 32'd42);
        chk("single_busy_cycles", busy_n, 5);
        chk("single_idle_cycle", idle_at, 6);

        // Contention: both requesters valid continuously
        do_reset();
        req_op[0] = OP_MUL;  req_rs1[0] = 32'd3;   req_rs2[0] = 32'd5;
        req_op[1] = OP_DIVU; req_rs1[1] = 32'd100; req_rs2[1] = 32'd7;
        ng = 0; nr = 0;
        for (int k = 0; k < 26; k++) begin
            adv();
            req_valid = 2'b11;
            smp();
            if ((|req_ready) && ng < 4) begin gseq[ng] = req_ready; ng++; end
            if ((|resp_valid) && nr < 4) begin
                rseq[nr] = resp_valid; dseq[nr] = resp_data; nr++;
            end
        end
        adv();
        req_valid = 2'b00;
        smp();
        for (int i = 0; i < 40 && busy; i++) begin adv(); smp(); end
        chk("cont_drain_idle", 32'(busy), 32'd0);
        chk("cont_num_grants", ng, 4);
        chk("cont_num_resps", nr, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_grant%0d", i), 32'(gseq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("cont_resp_owner%0d", i), 32'(rseq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("cont_resp_data%0d", i), dseq[i], (i % 2 == 0) ? 32'd15 : 32'd14);
        end

        // Flush in WAIT coinciding with unit_done
        do_reset();
        req_op[0] = OP_MUL; req_rs1[0] = 32'd7; req_rs2[0] = 32'd6;
        observe(2'b01, 8, 4, -1, -1, -1);
        chk("fwait_kill_cycle", kl_at, 5);
        chk("fwait_no_resp", rv_at, -1);
        chk("fwait_idle_cycle", idle_at, 5);
        chk("fwait_no_timeout", to_at, -1);
        observe(2'b10, 7, -1, -1, -1, -1);
        chk("fwait_next_ready", 32'(g0), 32'h2);
        chk("fwait_next_resp_cycle", rv_at, 5);
        chk("fwait_next_owner", 32'(rv), 32'h2);
        chk("fwait_next_data", rd, 32'd14);

        // Flush in START and in IDLE
        observe(2'b01, 5, 1, -1, -1, -1);
        chk("fstart_no_start", st_at, -1);
        chk("fstart_idle_cycle", idle_at, 2);
        chk("fstart_no_resp", rv_at, -1);
        observe(2'b01, 3, 0, -1, -1, -1);
        chk("fidle_no_ready", 32'(g0), 32'h0);
        chk("fidle_stays_idle", idle_at, 1);

        // Flush in RESP: response suppressed, round-robin pointer unchanged
        do_reset();
        req_op[0] = OP_MUL;  req_rs1[0] = 32'd7;   req_rs2[0] = 32'd6;
        req_op[1] = OP_DIVU; req_rs1[1] = 32'd100; req_rs2[1] = 32'd7;
        observe(2'b01, 7, 5, -1, -1, -1);
        chk("fresp_no_resp", rv_at, -1);
        chk("fresp_idle_cycle", idle_at, 6);
        chk("fresp_no_kill", kl_at, -1);
        observe(2'b11, 7, -1, -1, -1, -1);
        chk("fresp_same_winner", 32'(g0), 32'h1);
        chk("fresp_next_owner", 32'(rv), 32'h1);
        chk("fresp_next_data", rd, 32'd42);

        // Watchdog: MDU never completes
        mdu_en = 1'b0;
        observe(2'b01, 12, -1, -1, -1, -1);
        chk("tmo_start_cycle", st_at, 1);
        chk("tmo_kill_cycle", kl_at, 9);
        chk("tmo_err_cycle", to_at, 9);
        chk("tmo_no_resp", rv_at, -1);
        chk("tmo_idle_cycle", idle_at, 9);
        chk("tmo_busy_cycles", busy_n, 8);

        // Reset mid-WAIT, then a late unit_done in IDLE
        req_op[0] = OP_MUL; req_rs1[0] = 32'd9; req_rs2[0] = 32'd9;
        observe(2'b01, 9, -1, 4, 3, 4);
        chk("rstwait_outputs_zero", 32'(snap_any), 32'd0);
        chk("rstwait_no_resp", rv_at, -1);
        chk("rstwait_no_kill", kl_at, -1);
        chk("rstwait_idle_cycle", idle_at, 4);
        mdu_en = 1'b1;
        observe(2'b01, 7, -1, -1, -1, -1);
        chk("rstwait_next_ready", 32'(g0), 32'h1);
        chk("rstwait_next_data", rd, 32'd81);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
